fifo_rd_packer: RTL and testbench



---
 rtl/fifo_rd_packer.sv | 144 ++++++++++++++
 tb/tb_fifo_rd_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops `pack` narrow words and presents them as one wide word.
// Optional partial-word flush after `timeout` idle cycles when PACK_TIMEOUT_EN is defined.
module fifo_rd_packer #(
  parameter int unsigned data_width = 8,
  parameter int unsigned pack       = 4,
  parameter int unsigned timeout    = 16,
  parameter int unsigned cnt_width  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_empty,
  output logic                         fifo_rd,
  input  logic [data_width-1:0]        fifo_rd_data,
  output logic [data_width*pack-1:0]   out_data,
  output logic [pack-1:0]              out_keep,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [cnt_width-1:0]         out_cnt
);

  localparam int unsigned cw = $clog2(pack + 1);
  localparam logic [cw-1:0] pack_c = cw'(pack);
  localparam logic [cw-1:0] last_c = cw'(pack - 1);

  if (pack < 2 || timeout < 1) begin : g_param_check
    $error("fifo_rd_packer: pack must be >= 2 and timeout >= 1");
  end

  typedef enum logic {FILL, OUT} state_e;

  state_e                       state_q, state_d;
  logic [cw-1:0]                pop_cnt_q, pop_cnt_d;
  logic [cw-1:0]                cap_cnt_q, cap_cnt_d;
  logic                         rd_pend_q, rd_pend_d;
  logic [data_width*pack-1:0]   acc_q, acc_d;
  logic [pack-1:0]              keep_q, keep_d;
  logic                         valid_q, valid_d;
  logic [cnt_width-1:0]         cnt_q, cnt_d;
`ifdef PACK_TIMEOUT_EN
  localparam int unsigned iw = $clog2(timeout + 1);
  localparam logic [iw-1:0] idle_last_c = iw'(timeout - 1);
  logic [iw-1:0]                idle_q, idle_d;
`endif

  // Pop only while filling; OUT never overlaps with the next fill.
  assign fifo_rd = !rst && !fifo_empty && (state_q == FILL) && (pop_cnt_q < pack_c);

  always_comb begin
    state_d   = state_q;
    pop_cnt_d = pop_cnt_q;
    cap_cnt_d = cap_cnt_q;
    rd_pend_d = fifo_rd;
    acc_d     = acc_q;
    keep_d    = keep_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
`ifdef PACK_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    case (state_q)
      FILL: begin
        if (fifo_rd) pop_cnt_d = pop_cnt_q + 1'b1;
        if (rd_pend_q) begin
          for (int unsigned i = 0; i < pack; i++) begin
            if (cap_cnt_q == cw'(i)) acc_d[i*data_width +: data_width] = fifo_rd_data;
          end
          cap_cnt_d = cap_cnt_q + 1'b1;
`ifdef PACK_TIMEOUT_EN
          idle_d    = '0;
`endif
          if (cap_cnt_q == last_c) begin
            state_d = OUT;
            valid_d = 1'b1;
            keep_d  = '1;
          end
        end
`ifdef PACK_TIMEOUT_EN
        // Nothing in flight and the FIFO is dry: count towards a partial flush.
        else if (cap_cnt_q != '0 && fifo_empty) begin
          if (idle_q == idle_last_c) begin
            state_d = OUT;
            valid_d = 1'b1;
            idle_d  = '0;
            for (int unsigned i = 0; i < pack; i++) begin
              keep_d[i] = (cw'(i) < cap_cnt_q);
            end
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
`endif
      end
      OUT: begin
        if (out_ready) begin
          cnt_d     = cnt_q + 1'b1;
          acc_d     = '0;
          pop_cnt_d = '0;
          cap_cnt_d = '0;
          keep_d    = '0;
          valid_d   = 1'b0;
          state_d   = FILL;
`ifdef PACK_TIMEOUT_EN
          idle_d    = '0;
`endif
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      pop_cnt_q <= '0;
      cap_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      acc_q     <= '0;
      keep_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
`ifdef PACK_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pop_cnt_q <= pop_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      rd_pend_q <= rd_pend_d;
      acc_q     <= acc_d;
      keep_q    <= keep_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
`ifdef PACK_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  assign out_data  = acc_q;
  assign out_keep  = keep_q;
  assign out_valid = valid_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model with registered read, scoreboard of popped words,
// directed scenarios followed by randomized traffic.
module tb_fifo_rd_packer;
  localparam int unsigned DW = 8;
  localparam int unsigned PK = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DW-1:0]     fifo_rd_data;
  logic [DW*PK-1:0]  out_data;
  logic [PK-1:0]     out_keep;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_cnt;

  fifo_rd_packer #(
    .data_width(DW),
    .pack(PK),
    .timeout(TO),
    .cnt_width(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd),
    .fifo_rd_data(fifo_rd_data),
    .out_data(out_data),
    .out_keep(out_keep),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  bit gap = 1'b0;
  bit gap_toggle = 1'b0;
  int acc_cnt = 0;
  int pops = 0;
  int n_out = 0;
  int cyc = 0;
  logic [DW*PK-1:0] last_out = '0;
  bit pop_s, rst_s;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sample();
    logic [DW*PK-1:0] exp_data;
    logic [PK-1:0]    exp_keep;
    int unsigned      n;
    @(negedge clk);
    cyc++;
    check("no_underflow", 64'(fifo_rd & fifo_empty), 64'(0));
    if (rst) check("rd_in_rst", 64'(fifo_rd), 64'(0));
    if (out_valid) check("rd_in_out", 64'(fifo_rd), 64'(0));
    else check("keep_idle", 64'(out_keep), 64'(0));
    if (!rst && out_valid && out_ready) begin
      n = sb.size();
      exp_data = '0;
      exp_keep = '0;
      for (int unsigned i = 0; i < n && i < PK; i++) begin
        exp_data[i*DW +: DW] = sb[i];
        exp_keep[i] = 1'b1;
      end
`ifndef PACK_TIMEOUT_EN
      exp_keep = '1;
`endif
      check("out_data", 64'(out_data), 64'(exp_data));
      check("out_keep", 64'(out_keep), 64'(exp_keep));
      check("out_cnt", 64'(out_cnt), 64'(CW'(acc_cnt)));
      sb.delete();
      acc_cnt++;
      n_out++;
      last_out = out_data;
    end
    pop_s = fifo_rd;
    rst_s = rst;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (rst_s) begin
      sb.delete();
      acc_cnt = 0;
    end
    if (pop_s && fq.size() > 0) begin
      fifo_rd_data = fq.pop_front();
      sb.push_back(fifo_rd_data);
      pops++;
    end else begin
      fifo_rd_data = DW'($urandom);
    end
    if (gap_toggle) gap = ~gap;
    fifo_empty = (fq.size() == 0) || gap;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic wait_out(input string tag, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      sample();
      if (out_valid) seen = 1'b1;
      advance();
    end
    if (!seen) check(tag, 64'(0), 64'(1));
  endtask

  initial begin
    int first;
    bit done;
    logic [DW*PK-1:0] hold;
    int occ, p0;
    logic [DW*PK-1:0] o1;

    rst = 1'b1;
    fifo_empty = 1'b1;
    out_ready = 1'b0;
    fifo_rd_data = '0;

    repeat (3) begin
      sample();
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_keep", 64'(out_keep), 64'(0));
      check("rst_rd", 64'(fifo_rd), 64'(0));
      check("rst_cnt", 64'(out_cnt), 64'(0));
      advance();
    end
    rst = 1'b0;

    // Steady stream
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    out_ready = 1'b1;
    first = -1;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      sample();
      if (fifo_rd && first < 0) first = cyc;
      if (first >= 0 && cyc - first < 4) check("rd_burst", 64'(fifo_rd), 64'(1));
      if (out_valid) begin
        check("steady_lat", 64'(cyc - first), 64'(5));
        check("steady_data", 64'(out_data), 64'(32'h44332211));
        done = 1'b1;
      end
      advance();
    end
    if (!done) check("steady_seen", 64'(0), 64'(1));
    sample();
    check("steady_cnt", 64'(out_cnt), 64'(1));
    advance();

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(DW'(8'hB0 + i));
    wait_out("bp_seen", 30);
    hold = out_data;
    occ = fq.size();
    repeat (10) begin
      sample();
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_data", 64'(out_data), 64'(hold));
      check("bp_rd", 64'(fifo_rd), 64'(0));
      check("bp_occ", 64'(fq.size()), 64'(occ));
      advance();
    end
    out_ready = 1'b1;
    tick();
    sample();
    check("bp_rd_next", 64'(fifo_rd), 64'(1));
    advance();
    wait_out("bp_second", 30);

    // Gapped input
    gap_toggle = 1'b1;
    p0 = pops;
    for (int i = 0; i < 8; i++) fq.push_back(DW'(8'hA0 + i));
    wait_out("gap_first", 40);
    o1 = last_out;
    wait_out("gap_second", 40);
    check("gap_out1", 64'(o1), 64'(32'hA3A2A1A0));
    check("gap_out2", 64'(last_out), 64'(32'hA7A6A5A4));
    gap_toggle = 1'b0;
    gap = 1'b0;
    repeat (4) tick();
    check("gap_pops", 64'(pops - p0), 64'(8));
    check("gap_fifo_drained", 64'(fq.size()), 64'(0));

    // Reset mid-fill
    fq.push_back(8'hE1); fq.push_back(8'hE2);
    repeat (6) tick();
    sample();
    check("rmf_no_valid", 64'(out_valid), 64'(0));
    advance();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03); fq.push_back(8'h04);
    wait_out("rmf_seen", 30);
    check("rmf_data", 64'(last_out), 64'(32'h04030201));

    // Idle flush of a partial word
    fq.push_back(8'h55); fq.push_back(8'h66);
    first = -1;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      sample();
      if (fifo_rd && first < 0) first = cyc;
      if (out_valid) begin
`ifdef PACK_TIMEOUT_EN
        check("to_lat", 64'(cyc - first), 64'(3 + TO));
        check("to_data", 64'(out_data), 64'(32'h00006655));
        check("to_keep", 64'(out_keep), 64'(4'b0011));
`endif
        done = 1'b1;
      end
      advance();
    end
`ifdef PACK_TIMEOUT_EN
    check("to_seen", 64'(done), 64'(1));
`else
    check("no_flush", 64'(done), 64'(0));
    fq.push_back(8'h77); fq.push_back(8'h88);
    wait_out("complete_seen", 30);
    check("complete_data", 64'(last_out), 64'(32'h88776655));
`endif

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 16) fq.push_back(DW'($urandom));
      gap = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    gap = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
